// File: rtl/mem_pkg.sv
// Shared definitions for the line-memory arbiter: FSM encoding, grant ids and
// default geometry.
package mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GAP
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not served last
// wins; otherwise the single requester wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic any_o
);

  always_comb begin
    any_o = ic_req_i | dc_req_i;
    if (ic_req_i && dc_req_i) begin
      grant_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
    end else if (dc_req_i) begin
      grant_o = GNT_D;
    end else begin
      grant_o = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single backing line memory between I-cache refills and
// D-cache refills/write-backs; one read transaction outstanding at a time.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_line,
  output logic              ic_valid,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic [LINE_W-1:0] dc_line,
  output logic              dc_valid,
  input  logic              dc_wb_we,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [LINE_W-1:0] dc_wb_wline,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [LINE_W-1:0] mem_rd_line,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [LINE_W-1:0] mem_wline
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cap_q;
  logic [LINE_W-1:0]   line_q;
  logic                arb_gnt, arb_any;
  logic                rd_issue;

  rr_arb2 u_rr (
    .ic_req_i     (ic_req),
    .dc_req_i     (dc_req),
    .last_grant_i (last_q),
    .grant_o      (arb_gnt),
    .any_o        (arb_any)
  );

  // Write-backs go straight through; the FSM keeps reads out of those cycles.
  assign mem_we    = dc_wb_we & ~rst;
  assign mem_waddr = rst ? '0 : dc_wb_addr;
  assign mem_wline = rst ? '0 : dc_wb_wline;

  assign ic_line = line_q;
  assign dc_line = line_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rd_issue = 1'b0;
    ic_valid = 1'b0;
    dc_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any && !dc_wb_we) begin
          gnt_d   = arb_gnt;
          addr_d  = (arb_gnt == GNT_D) ? dc_addr : ic_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A stray write-back here holds the issue so memory sees it first.
        if (!dc_wb_we) begin
          rd_issue = 1'b1;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ic_valid = ~rst & (gnt_q == GNT_I);
        dc_valid = ~rst & (gnt_q == GNT_D);
        last_d   = gnt_q;
        state_d  = (gnt_q == GNT_D) ? GAP : IDLE;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_rd_en   = rd_issue & ~rst;
  assign mem_rd_addr = mem_rd_en ? addr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_I;
      last_q  <= GNT_I;
      addr_q  <= '0;
      cnt_q   <= '0;
      cap_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      // Synchronous memory: data for an issue appears the following cycle.
      cap_q   <= mem_rd_en;
      if (cap_q) begin
        line_q <= mem_rd_line;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single backing line memory between the I-cache refill port and the D-cache refill/write-back ports. Holds level-sensitive line-read requests, grants one at a time using round-robin, and issues the read. Waits a fixed memory latency, then returns the 128-bit line with a one-cycle valid pulse to the granted cache. D-cache write-backs pass straight to memory, and reads are ordered behind them so a refill never returns stale data.

Parameters:
ADDR_W, 10, line-address width.
LINE_W, 128, line width (4 x 32-bit words).
MEM_LAT, 4, cycles from read issue to requester valid pulse; must be >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ic_req  in  1  I-cache line request, level, held until ic_valid
ic_addr  in  ADDR_W  I-cache line address
ic_line  out  LINE_W  returned line (shared line register)
ic_valid  out  1  one-cycle pulse: ic_line valid
dc_req  in  1  D-cache line request, level, held until dc_valid
dc_addr  in  ADDR_W  D-cache line address
dc_line  out  LINE_W  returned line (shared line register)
dc_valid  out  1  one-cycle pulse: dc_line valid
dc_wb_we  in  1  D-cache write-back strobe
dc_wb_addr  in  ADDR_W  write-back line address
dc_wb_wline  in  LINE_W  write-back data
mem_rd_en  out  1  memory read enable
mem_rd_addr  out  ADDR_W  memory read line address
mem_rd_line  in  LINE_W  memory read data, valid the cycle after mem_rd_en (sync read)
mem_we  out  1  memory write enable
mem_waddr  out  ADDR_W  memory write address
mem_wline  out  LINE_W  memory write data

Behaviour:
- Reset values: state IDLE; all outputs 0; line register 0; counter 0; last_grant = I, so D wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - Grant if any req is high and dc_wb_we is low.
  - Both requesting: grant the one not equal to last_grant.
  - Latch grant id and address; go to ISSUE.
  - If dc_wb_we is high, no grant that cycle.
- ISSUE (cycle s): mem_rd_en=1, mem_rd_addr=latched address; counter loads MEM_LAT-1; go to WAIT.
- WAIT:
  - First WAIT cycle (s+1): capture mem_rd_line into the line register.
  - Counter decrements each cycle; at 1, go to RESP.
- RESP (cycle s+MEM_LAT):
  - Pulse ic_valid or dc_valid for the granted requester only.
  - Update last_grant.
  - Next state is GAP if D was granted, else IDLE.
- GAP: one idle cycle absorbing the D-cache's registered write-back (it arrives the cycle after dc_valid); go to IDLE.
- Latency: req seen in idle IDLE at t -> mem_rd_en at t+1 -> valid at t+1+MEM_LAT.
- ic_line and dc_line both show the line register continuously; they are meaningful only with the matching valid.
- Write-back path: mem_we=dc_wb_we, mem_waddr=dc_wb_addr, mem_wline=dc_wb_wline. Combinational pass-through in any state, gated to 0 during rst.
- A read is never issued in a cycle with mem_we=1.
- Requester drops req before RESP (flush): the transaction still completes and the valid pulse still fires; the requester ignores it.
- Requester changes address while pending: ignored; the latched address is used.
- Write-back to the address currently in WAIT: memory is updated, but the in-flight line is not patched (the D-cache never does this to an outstanding line).
- Reset mid-operation (any state): next cycle is IDLE; no valid pulse; mem_rd_en=0; captured line cleared.
- Only one transaction is outstanding; no queueing beyond the level-held requests.

Decomposition:
- Shared package (mem_pkg): state encoding IDLE/ISSUE/WAIT/RESP/GAP; grant id constants GNT_I=0, GNT_D=1; ADDR_W/LINE_W defaults.
- Sub-module rr_arb2: 2-way round-robin picker (req_i, req_d, last_grant -> grant id, any). Everything else stays in mem_arbiter.

Test Plan:
1. MEM_LAT=4, dc_req addr 0x005 at cycle 0, memory holds line A at 0x005 -> mem_rd_en/addr 0x005 at cycle 1; dc_valid at cycle 5 with dc_line=A; ic_valid stays 0.
2. ic_req 0x010 and dc_req 0x020 both at cycle 0 after reset -> D issued at cycle 1, dc_valid at cycle 5, GAP at cycle 6, I issued at cycle 8, ic_valid at cycle 12.
3. After test 2's dc_valid, drive dc_wb_we at cycle 6 (addr 0x020, line W) -> mem_we=1 at cycle 6 and no read issued that cycle; a later dc_req 0x020 returns W.
4. ic_req and dc_req held continuously for 4 transactions -> grant order D, I, D, I; exactly one valid pulse per transaction.
5. dc_req at cycle 0, rst at cycle 3 (WAIT) -> no dc_valid ever, all outputs 0 at cycle 4; a fresh ic_req at cycle 5 gets ic_valid at cycle 10.
6. MEM_LAT=2, ic_req 0x3FF at cycle 0 -> mem_rd_en at cycle 1, ic_valid at cycle 3 with the line stored at 0x3FF.
